// File: rtl/uart_tx_scheduler.sv
// Periodic and on-demand transmit request generator: N_CH channels with programmable
// periods and manual triggers, round-robin arbitrated onto one UART send/ready handshake.
module uart_tx_scheduler #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 24,
    parameter int ACK_TO = 255
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic [N_CH*CNT_W-1:0]               period,
    input  logic [N_CH-1:0]                     trig,
    input  logic                                tx_ready,
    output logic                                tx_send,
    output logic [((N_CH>1)?$clog2(N_CH):1)-1:0] tx_chan,
    output logic [N_CH-1:0]                     overrun,
    output logic                                ack_err,
    input  logic                                clear
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TO_W = (ACK_TO > 1) ? $clog2(ACK_TO + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [N_CH];
    logic [CNT_W-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0]    tick, evt, grant;
    logic [N_CH-1:0]    pending_q, pending_d;
    logic [N_CH-1:0]    overrun_q, overrun_d;
    logic [CH_W-1:0]    rr_q, rr_d;
    logic [CH_W-1:0]    tx_chan_q, tx_chan_d;
    logic [CH_W-1:0]    pick;
    logic               found;
    logic               tx_send_q, tx_send_d;
    logic               ack_err_q, ack_err_d;
    logic               ack_to_hit;
    logic [TO_W-1:0]    timer_q, timer_d;

    // The >= compare makes a period lowered below the running count fire immediately.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            tick[i]  = 1'b0;
            cnt_d[i] = cnt_q[i];
            if (period[i*CNT_W +: CNT_W] == '0) begin
                cnt_d[i] = '0;
            end else if (enable) begin
                if (cnt_q[i] >= period[i*CNT_W +: CNT_W]) begin
                    cnt_d[i] = '0;
                    tick[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        evt = tick | trig;
    end

    // Round-robin scan starting just after the last granted channel.
    always_comb begin
        logic [CH_W:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= N_CH; off++) begin
            idx = {1'b0, rr_q} + (CH_W+1)'(off);
            if (idx >= (CH_W+1)'(N_CH)) begin
                idx = idx - (CH_W+1)'(N_CH);
            end
            if (!found && pending_q[idx[CH_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_send_d  = 1'b0;
        tx_chan_d  = tx_chan_q;
        rr_d       = rr_q;
        grant      = '0;
        timer_d    = timer_q;
        ack_to_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_ready && found) begin
                    tx_send_d   = 1'b1;
                    tx_chan_d   = pick;
                    rr_d        = pick;
                    grant[pick] = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                timer_d = '0;
                state_d = ACK;
            end
            ACK: begin
                if (!tx_ready) begin
                    state_d = DRAIN;
                end else if (timer_q == TO_W'(ACK_TO - 1)) begin
                    ack_to_hit = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DRAIN: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An event landing on the granted channel re-arms it instead of counting as lost.
    always_comb begin
        pending_d = evt | (pending_q & ~grant);
        overrun_d = (clear ? '0 : overrun_q) | (evt & pending_q & ~grant);
        ack_err_d = (clear ? 1'b0 : ack_err_q) | ack_to_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            state_q   <= IDLE;
            pending_q <= '0;
            overrun_q <= '0;
            rr_q      <= CH_W'(N_CH - 1);
            tx_chan_q <= '0;
            tx_send_q <= 1'b0;
            ack_err_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rr_q      <= rr_d;
            tx_chan_q <= tx_chan_d;
            tx_send_q <= tx_send_d;
            ack_err_q <= ack_err_d;
            timer_q   <= timer_d;
        end
    end

    assign tx_send = tx_send_q;
    assign tx_chan = tx_chan_q;
    assign overrun = overrun_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: arbitration vector table plus hand sequences for
// periodic ticks, overrun, ACK timeout, period/enable changes and mid-transaction reset.
module tb_uart_tx_scheduler;

    localparam int N_CH  = 4;
    localparam int CNT_W = 24;

    logic                    clk     = 1'b0;
    logic                    rst_n   = 1'b0;
    logic                    enable  = 1'b0;
    logic                    clear   = 1'b0;
    logic [N_CH*CNT_W-1:0]   period  = '0;
    logic [N_CH-1:0]         trig    = '0;
    logic                    tx_ready;
    logic                    tx_send;
    logic [1:0]              tx_chan;
    logic [N_CH-1:0]         overrun;
    logic                    ack_err;

    // uartMode: 0 = UART model, 1 = ready stuck low, 2 = ready stuck high
    int   uartMode   = 0;
    logic modelReady = 1'b1;
    int   busyCnt    = 0;
    int   busyLen    = 3;

    int         cycle = 0;
    int         sendCycles[$];
    logic [1:0] sendChans[$];
    int         vectors     = 0;
    int         miscompares = 0;

    typedef struct {
        logic [3:0]      mask;
        int              nExp;
        logic [3:0][1:0] chans;
    } arbVec_t;

    arbVec_t arbTab[7];

    uart_tx_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W), .ACK_TO(255)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .period   (period),
        .trig     (trig),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .tx_chan  (tx_chan),
        .overrun  (overrun),
        .ack_err  (ack_err),
        .clear    (clear)
    );

    assign tx_ready = (uartMode == 0) ? modelReady : (uartMode == 2);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle++;
        #1;
        if (tx_send) begin
            sendCycles.push_back(cycle);
            sendChans.push_back(tx_chan);
        end
    end

    // UART model: drops ready the cycle after a send, raises it busyLen+1 cycles later.
    always @(negedge clk) begin
        if (uartMode == 0) begin
            if (tx_send) begin
                modelReady = 1'b0;
                busyCnt    = busyLen;
            end else if (!modelReady) begin
                if (busyCnt == 0) modelReady = 1'b1;
                else busyCnt--;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] mask);
        @(negedge clk);
        trig = mask;
        @(negedge clk);
        trig = '0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitSend(input int idx, input int maxCyc, output int cyc);
        cyc = -1;
        for (int k = 0; k < maxCyc; k++) begin
            @(negedge clk);
            if (sendCycles.size() > idx) begin
                cyc = sendCycles[idx];
                break;
            end
        end
    endtask

    initial begin
        int start, c, s, got;

        arbTab[0] = '{4'b1111, 4, 8'b11_10_01_00};
        arbTab[1] = '{4'b0011, 2, 8'b00_00_01_00};
        arbTab[2] = '{4'b0100, 1, 8'b00_00_00_10};
        arbTab[3] = '{4'b0101, 2, 8'b00_00_10_00};
        arbTab[4] = '{4'b1010, 2, 8'b00_00_01_11};
        arbTab[5] = '{4'b1001, 2, 8'b00_00_00_11};
        arbTab[6] = '{4'b0110, 2, 8'b00_00_10_01};

        waitCycles(3);
        checkOutput("reset tx_send", tx_send, 0);
        checkOutput("reset tx_chan", tx_chan, 0);
        checkOutput("reset overrun", overrun, 0);
        checkOutput("reset ack_err", ack_err, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        waitCycles(2);

        $display("[TB] round-robin table");
        for (int r = 0; r < 7; r++) begin
            start = sendChans.size();
            applyStimulus(arbTab[r].mask);
            waitCycles(45);
            checkOutput("arb count", sendChans.size() - start, arbTab[r].nExp);
            for (int k = 0; k < arbTab[r].nExp; k++) begin
                if (start + k < sendChans.size())
                    checkOutput("arb chan", sendChans[start+k], arbTab[r].chans[k]);
            end
        end
        checkOutput("arb overrun", overrun, 0);

        $display("[TB] periodic channel 0, period 9");
        start = sendCycles.size();
        c = cycle;
        period[0 +: CNT_W] = 24'd9;
        waitCycles(100);
        checkOutput("periodic count", sendCycles.size() - start, 9);
        if (sendCycles.size() > start)
            checkOutput("periodic first", sendCycles[start], c + 11);
        for (int k = 1; k < 9; k++) begin
            if (start + k < sendCycles.size()) begin
                checkOutput("periodic spacing", sendCycles[start+k] - sendCycles[start+k-1], 10);
                checkOutput("periodic chan", sendChans[start+k], 0);
            end
        end
        checkOutput("periodic overrun", overrun, 0);
        period = '0;
        waitCycles(20);

        $display("[TB] overrun with ready low");
        uartMode = 1;
        start = sendChans.size();
        applyStimulus(4'b0010);
        waitCycles(4);
        applyStimulus(4'b0010);
        waitCycles(2);
        checkOutput("overrun set", overrun, 4'b0010);
        checkOutput("no send while busy", sendChans.size() - start, 0);
        uartMode = 0;
        waitCycles(15);
        checkOutput("merged send count", sendChans.size() - start, 1);
        if (sendChans.size() > start)
            checkOutput("merged send chan", sendChans[start], 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("overrun cleared", overrun, 0);

        $display("[TB] event coinciding with grant");
        uartMode = 1;
        start = sendChans.size();
        applyStimulus(4'b0001);
        waitCycles(2);
        @(negedge clk);
        uartMode = 0;
        trig = 4'b0001;
        @(negedge clk);
        trig = '0;
        waitCycles(20);
        checkOutput("coincide count", sendChans.size() - start, 2);
        for (int k = 0; k < 2; k++) begin
            if (start + k < sendChans.size())
                checkOutput("coincide chan", sendChans[start+k], 0);
        end
        checkOutput("coincide overrun", overrun, 0);

        $display("[TB] ACK timeout");
        uartMode = 2;
        start = sendChans.size();
        applyStimulus(4'b0100);
        waitCycles(10);
        checkOutput("timeout send count", sendChans.size() - start, 1);
        if (sendChans.size() > start)
            checkOutput("timeout send chan", sendChans[start], 2);
        waitCycles(190);
        checkOutput("ack_err early", ack_err, 0);
        waitCycles(100);
        checkOutput("ack_err set", ack_err, 1);
        checkOutput("no resend", sendChans.size() - start, 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("ack_err cleared", ack_err, 0);
        uartMode = 0;
        waitCycles(5);

        $display("[TB] period change and enable freeze");
        period[3*CNT_W +: CNT_W] = 24'd100;
        waitCycles(50);
        start = sendCycles.size();
        c = cycle;
        period[3*CNT_W +: CNT_W] = 24'd20;
        waitSend(start, 10, got);
        checkOutput("lowered period first", got, c + 2);
        if (sendChans.size() > start)
            checkOutput("lowered period chan", sendChans[start], 3);
        waitSend(start + 1, 30, got);
        checkOutput("period 20 spacing", got, c + 23);
        s = cycle;
        enable = 1'b0;
        waitCycles(30);
        checkOutput("frozen no tick", sendCycles.size() - start, 2);
        enable = 1'b1;
        waitSend(start + 2, 40, got);
        checkOutput("resume from held", got, s + 51);
        period = '0;
        waitCycles(10);

        $display("[TB] reset during ACK");
        uartMode = 2;
        applyStimulus(4'b0100);
        waitCycles(3);
        applyStimulus(4'b1010);
        waitCycles(2);
        applyStimulus(4'b1010);
        waitCycles(1);
        checkOutput("pre-reset overrun", overrun, 4'b1010);
        checkOutput("pre-reset chan", tx_chan, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async tx_send", tx_send, 0);
        checkOutput("async tx_chan", tx_chan, 0);
        checkOutput("async overrun", overrun, 0);
        checkOutput("async ack_err", ack_err, 0);
        waitCycles(3);
        rst_n    = 1'b1;
        uartMode = 0;
        start = sendChans.size();
        waitCycles(30);
        checkOutput("no send after reset", sendChans.size() - start, 0);
        applyStimulus(4'b1001);
        waitCycles(20);
        checkOutput("post-reset count", sendChans.size() - start, 2);
        if (sendChans.size() > start + 1) begin
            checkOutput("post-reset first chan", sendChans[start], 0);
            checkOutput("post-reset second chan", sendChans[start+1], 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
